// File: rtl/mat_result_tx_if.sv
// mat_result_tx_if: byte-stream handshake between the result serializer and the UART TX.
//
// Signals:
//   tx_byte   byte currently offered by the master
//   tx_valid  tx_byte is valid
//   tx_ready  slave can accept a byte; a transfer occurs when tx_valid && tx_ready
//
// Modports:
//   master  drives tx_byte/tx_valid, samples tx_ready (mat_result_tx)
//   slave   samples tx_byte/tx_valid, drives tx_ready (UART TX byte interface)

interface mat_result_tx_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_byte,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_byte,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/mat_result_tx.sv
// mat_result_tx: serializes one 2x2 matrix product into a framed byte stream for the UART.
//
// A start pulse in IDLE captures job_id and c11..c22. The frame is then offered one byte
// at a time on the tx handshake:
//   0xFF, job_id, c11, c12, c21, c22 [, checksum]
// The checksum is the XOR of job_id and c11..c22 (the header is excluded). It is present
// only when the macro MAT_RESULT_TX_CHECKSUM_EN is defined; by default the frame is 6 bytes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle send request, honoured only in IDLE
//   job_id       job tag, captured on start
//   c11..c22     product elements, captured on start
//   tx           byte-stream master (tx_byte, tx_valid out; tx_ready in)
//   busy         frame in progress (SEND or DONE)
//   done         one-cycle pulse the cycle after the last byte transfers
//   frames_sent  completed frame count, wraps 255 -> 0
//
// All outputs come straight from registers; nothing combinational from start or tx_ready.

module mat_result_tx (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            job_id,
    input  logic [7:0]            c11,
    input  logic [7:0]            c12,
    input  logic [7:0]            c21,
    input  logic [7:0]            c22,
    mat_result_tx_if.master       tx,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frames_sent
);

`ifdef MAT_RESULT_TX_CHECKSUM_EN
    localparam int unsigned NumBytes = 7;
`else
    localparam int unsigned NumBytes = 6;
`endif
    localparam logic [2:0] LastIdx = 3'(NumBytes - 1);
    localparam logic [7:0] Header  = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] frames_q, frames_d;

    // Frame contents, frozen for the whole frame once start is accepted.
    logic [7:0] job_q, job_d;
    logic [7:0] c11_q, c11_d;
    logic [7:0] c12_q, c12_d;
    logic [7:0] c21_q, c21_d;
    logic [7:0] c22_q, c22_d;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic [2:0] idx_inc;
    logic [7:0] next_byte;
    logic       xfer;

    assign idx_inc = idx_q + 3'd1;
    assign xfer    = tx_valid_q && tx.tx_ready;

    // Byte that follows the one currently offered. Index 0 (header) is loaded directly
    // when the frame starts, so it never appears here.
    always_comb begin
        next_byte = 8'h00;
        case (idx_inc)
            3'd1:    next_byte = job_q;
            3'd2:    next_byte = c11_q;
            3'd3:    next_byte = c12_q;
            3'd4:    next_byte = c21_q;
            3'd5:    next_byte = c22_q;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
            3'd6:    next_byte = csum_q;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        frames_d   = frames_q;
        job_d      = job_q;
        c11_d      = c11_q;
        c12_d      = c12_q;
        c21_d      = c21_q;
        c22_d      = c22_q;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    job_d      = job_id;
                    c11_d      = c11;
                    c12_d      = c12;
                    c21_d      = c21;
                    c22_d      = c22;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
                    csum_d     = job_id ^ c11 ^ c12 ^ c21 ^ c22;
`endif
                    idx_d      = 3'd0;
                    tx_byte_d  = Header;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = StSend;
                end
            end

            StSend: begin
                // Without a transfer everything holds, which keeps tx_byte stable under
                // backpressure.
                if (xfer) begin
                    if (idx_q == LastIdx) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = StDone;
                    end else begin
                        idx_d     = idx_inc;
                        tx_byte_d = next_byte;
                    end
                end
            end

            StDone: begin
                busy_d   = 1'b0;
                frames_d = frames_q + 8'd1;
                idx_d    = 3'd0;
                state_d  = StIdle;
            end

            default: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                idx_d      = 3'd0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frames_q   <= 8'h00;
            job_q      <= 8'h00;
            c11_q      <= 8'h00;
            c12_q      <= 8'h00;
            c21_q      <= 8'h00;
            c22_q      <= 8'h00;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            frames_q   <= frames_d;
            job_q      <= job_d;
            c11_q      <= c11_d;
            c12_q      <= c12_d;
            c21_q      <= c21_d;
            c22_q      <= c22_d;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx.tx_byte  = tx_byte_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_mat_result_tx.sv
// Self-checking bench for mat_result_tx: table-driven frames with backpressure masks,
// plus hand-written reset, reset-priority and 256-frame wrap/back-to-back sequences.

module tb_mat_result_tx;

`ifdef MAT_RESULT_TX_CHECKSUM_EN
    localparam int N = 7;
`else
    localparam int N = 6;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] job_id, c11, c12, c21, c22;
    logic       busy, done;
    logic [7:0] frames_sent;

    mat_result_tx_if tx_if ();

    mat_result_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .job_id      (job_id),
        .c11         (c11),
        .c12         (c12),
        .c21         (c21),
        .c22         (c22),
        .tx          (tx_if),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    typedef struct {
        logic [7:0]  job;
        logic [7:0]  e11;
        logic [7:0]  e12;
        logic [7:0]  e21;
        logic [7:0]  e22;
        logic [7:0]  csum;    // hand-computed XOR of job and elements
        logic [15:0] mask;    // tx_ready per send cycle, bit 0 first, repeating
        bit          inject;  // pulse start and change inputs mid-frame
    } vec_t;

    vec_t vecs [6];

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;
    int frm_first, frm_last, frm_iters;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_now);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int k);
        case (k)
            0:       return 8'hFF;
            1:       return v.job;
            2:       return v.e11;
            3:       return v.e12;
            4:       return v.e21;
            5:       return v.e22;
            default: return v.csum;
        endcase
    endfunction

    // Entered and left at a negedge; on return the DUT is idle and a new start may be
    // applied straight away (back-to-back).
    task automatic run_frame(input vec_t v);
        int  k = 0;
        int  iters = 0;
        bit  stalled = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        logic rdy;

        start  = 1'b1;
        job_id = v.job;
        c11 = v.e11; c12 = v.e12; c21 = v.e21; c22 = v.e22;
        @(negedge clk);
        frm_first = cyc_now;
        while (k < N && iters < 200) begin
            check("send_valid", tx_if.tx_valid, 1'b1);
            check("send_busy", busy, 1'b1);
            check("send_no_done", done, 1'b0);
            if (stalled) check("stall_stable", tx_if.tx_byte, prev_byte);
            if (v.inject && iters == 2) begin
                start = 1'b1;
                c11 = ~v.e11; c12 = ~v.e12; c21 = ~v.e21; c22 = ~v.e22; job_id = ~v.job;
            end else begin
                start = 1'b0;
            end
            rdy = v.mask[iters % 16];
            tx_if.tx_ready = rdy;
            if (rdy) begin
                check($sformatf("byte%0d", k), tx_if.tx_byte, exp_byte(v, k));
                frm_last = cyc_now;
                k++;
            end
            stalled   = !rdy;
            prev_byte = tx_if.tx_byte;
            iters++;
            @(negedge clk);
        end
        start = 1'b0;
        frm_iters = iters;
        check("frame_complete", k, N);
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b1);
        check("done_valid", tx_if.tx_valid, 1'b0);
        @(negedge clk);
        exp_frames = (exp_frames + 1) % 256;
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_valid", tx_if.tx_valid, 1'b0);
        check("frames_sent", frames_sent, exp_frames);
        if (v.inject) begin
            repeat (4) begin
                @(negedge clk);
                check("no_second_frame", tx_if.tx_valid, 1'b0);
                check("no_second_busy", busy, 1'b0);
            end
        end
    endtask

    initial begin
        vec_t w;
        int   prev_last;

        vecs[0] = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 16'hFFFF, 1'b0};
        vecs[1] = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE5, 16'b0101_1010_0110_1101, 1'b0};
        vecs[2] = '{8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3C, 16'h8421, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF, 1'b1};
        vecs[4] = '{8'h7E, 8'h81, 8'h42, 8'h24, 8'h18, 8'h81, 16'hAAAB, 1'b1};
        vecs[5] = '{8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF7, 16'h7FFF, 1'b0};

        rst = 1'b1; start = 1'b0; tx_if.tx_ready = 1'b0;
        job_id = 8'h00; c11 = 8'h00; c12 = 8'h00; c21 = 8'h00; c22 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", tx_if.tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_byte", tx_if.tx_byte, 8'h00);
        check("rst_frames", frames_sent, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Reset after three transfers aborts the frame.
        start = 1'b1; job_id = 8'h11; c11 = 8'h22; c12 = 8'h33; c21 = 8'h44; c22 = 8'h55;
        @(negedge clk);
        start = 1'b0; tx_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_byte_before_rst", tx_if.tx_byte, 8'h33);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", tx_if.tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_frames", frames_sent, 8'h00);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_valid", tx_if.tx_valid, 1'b0);
        check("rst_prio_busy", busy, 1'b0);
        @(negedge clk);
        check("rst_prio_still_idle", tx_if.tx_valid, 1'b0);
        exp_frames = 0;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
            if (vecs[i].mask == 16'hFFFF) check("full_rate_cycles", frm_iters, N);
        end

        // 256 back-to-back frames from a cleared counter.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        prev_last = 0;
        for (int i = 0; i < 256; i++) begin
            w.job  = 8'(i);
            w.e11  = 8'hFF;
            w.e12  = 8'(i) ^ 8'h5A;
            w.e21  = 8'(255 - i);
            w.e22  = 8'(i * 3);
            w.csum = w.job ^ w.e11 ^ w.e12 ^ w.e21 ^ w.e22;
            w.mask = 16'hFFFF;
            w.inject = 1'b0;
            run_frame(w);
            if (i > 0) check("b2b_gap", frm_first - prev_last, 3);
            prev_last = frm_last;
        end
        check("wrap_frames", frames_sent, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc_now);
        $fatal(1);
    end

endmodule
